// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   ctrl_state_e : interrupt-entry sequencer states
//   pc_sel_e     : PC source select driven to the fetch stage
//   NOP_INSTR    : encoding loaded into a stage register on flush (addi x0,x0,0)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_HOLD  = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // MRET returns to the MEPC CSR; any other taken control transfer goes to EX's target.
  function automatic logic [31:0] redir_target(input logic        mret,
                                               input logic [31:0] br_target,
                                               input logic [31:0] mepc_csr);
    return mret ? mepc_csr : br_target;
  endfunction

endpackage

// File: rtl/mem_wait_wdt.sv
// SRAM wait watchdog.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_stall      : MEM stage is waiting on SRAM this cycle
//   o_mem_err    : one-cycle pulse on the MEM_TIMEOUT-th+1 consecutive stall cycle
// The counter holds the number of earlier consecutive stall cycles. When the pulse
// fires it wraps to zero, so a stall that keeps going pulses again every
// MEM_TIMEOUT+1 cycles.
module mem_wait_wdt #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stall,
  output logic o_mem_err
);

  localparam int WDT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(MEM_TIMEOUT);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d     = '0;
    o_mem_err = 1'b0;
    if (i_stall) begin
      if (wdt_q == WDT_MAX) begin
        o_mem_err = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Inputs : hazard sources (i_ld_use, i_br_taken/i_br_target, i_mret/i_mepc_csr,
//          i_mem_req/i_mem_ack, i_irq/i_irq_en/i_mtvec) and i_id_pc.
// Outputs: per-stage load enables o_en_*, flushes o_flush_* (load NOP, vld=0),
//          o_pc_sel/o_pc_redir, MEPC capture (o_mepc_we/o_mepc), o_irq_ack,
//          o_mem_err, and o_dbg_state exposing the sequencer state.
// All outputs are combinational from registered state and current inputs.
// Per-cycle priority: mem stall > branch/MRET > IRQ entry > load-use.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_use,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_mret,
  input  logic [31:0] i_mepc_csr,
  input  logic        i_mem_req,
  input  logic        i_mem_ack,
  input  logic        i_irq,
  input  logic        i_irq_en,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_id_pc,
  output logic        o_en_ifid,
  output logic        o_en_idex,
  output logic        o_en_exmem,
  output logic        o_en_memwb,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic        o_flush_exmem,
  output pc_sel_e     o_pc_sel,
  output logic [31:0] o_pc_redir,
  output logic        o_mepc_we,
  output logic [31:0] o_mepc,
  output logic        o_irq_ack,
  output logic        o_mem_err,
  output ctrl_state_e o_dbg_state
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

  ctrl_state_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]        mepc_q, mepc_d;
  // Set on trap entry, cleared once i_irq_en is seen low: a still-pending level
  // IRQ cannot re-enter until software re-enables interrupts.
  logic               irq_lock_q, irq_lock_d;

  logic        stall;
  logic        redir_req;
  logic [31:0] redir_pc;
  logic        irq_take;
  logic        wdt_err;

  assign stall     = i_mem_req & ~i_mem_ack;
  assign redir_req = i_br_taken | i_mret;
  assign redir_pc  = redir_target(i_mret, i_br_target, i_mepc_csr);
  assign irq_take  = i_irq & i_irq_en & ~irq_lock_q;

  mem_wait_wdt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stall  (stall),
    .o_mem_err(wdt_err)
  );

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    mepc_d        = mepc_q;
    irq_lock_d    = i_irq_en ? irq_lock_q : 1'b0;
    o_en_ifid     = 1'b1;
    o_en_idex     = 1'b1;
    o_en_exmem    = 1'b1;
    o_en_memwb    = 1'b1;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_flush_exmem = 1'b0;
    o_pc_sel      = PC_PLUS4;
    o_pc_redir    = 32'h0;
    o_mepc_we     = 1'b0;
    o_irq_ack     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (stall) begin
          {o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb} = 4'b0000;
          o_pc_sel = PC_HOLD;
        end else if (redir_req) begin
          o_flush_ifid = 1'b1;
          o_flush_idex = 1'b1;
          o_pc_sel     = PC_REDIR;
          o_pc_redir   = redir_pc;
        end else if (irq_take) begin
          // Squash ID; its PC is where execution resumes after the handler.
          o_flush_ifid = 1'b1;
          o_pc_sel     = PC_HOLD;
          mepc_d       = i_id_pc;
          drain_cnt_d  = DRAIN_INIT;
          state_d      = ST_DRAIN;
        end else if (i_ld_use) begin
          o_en_ifid    = 1'b0;
          o_flush_idex = 1'b1;
          o_pc_sel     = PC_HOLD;
        end
      end

      ST_DRAIN: begin
        // ID holds only squashed slots while draining, so load-use is moot here.
        if (stall) begin
          {o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb} = 4'b0000;
          o_pc_sel = PC_HOLD;
        end else begin
          o_flush_ifid = 1'b1;
          o_pc_sel     = PC_HOLD;
          drain_cnt_d  = drain_cnt_q - 1'b1;
          // A redirect in EX retargets the return address instead of the PC.
          if (redir_req) begin
            mepc_d       = redir_pc;
            o_flush_idex = 1'b1;
          end
          if (drain_cnt_q == DRAIN_LAST) state_d = ST_TRAP;
        end
      end

      ST_TRAP: begin
        // Pipe is already empty: this cycle ignores stalls.
        o_flush_ifid = 1'b1;
        o_pc_sel     = PC_REDIR;
        o_pc_redir   = i_mtvec;
        o_mepc_we    = 1'b1;
        o_irq_ack    = 1'b1;
        irq_lock_d   = 1'b1;
        state_d      = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    if (i_rst) begin
      o_en_ifid     = 1'b1;
      o_en_idex     = 1'b1;
      o_en_exmem    = 1'b1;
      o_en_memwb    = 1'b1;
      o_flush_ifid  = 1'b1;
      o_flush_idex  = 1'b1;
      o_flush_exmem = 1'b1;
      o_pc_sel      = PC_HOLD;
      o_pc_redir    = 32'h0;
      o_mepc_we     = 1'b0;
      o_irq_ack     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      mepc_q      <= 32'h0;
      irq_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      mepc_q      <= mepc_d;
      irq_lock_q  <= irq_lock_d;
    end
  end

  assign o_mepc      = mepc_q;
  assign o_mem_err   = wdt_err & ~i_rst;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DRAIN = 3;
  localparam int TMO   = 255;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_use, br_taken, mret, mem_req, mem_ack, irq, irq_en;
  logic [31:0] br_target, mepc_csr, mtvec, id_pc;
  logic        en_ifid, en_idex, en_exmem, en_memwb;
  logic        fl_ifid, fl_idex, fl_exmem;
  pc_sel_e     pc_sel;
  logic [31:0] pc_redir, mepc;
  logic        mepc_we, irq_ack, mem_err;
  ctrl_state_e dbg_state;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ld_use(ld_use), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_mret(mret), .i_mepc_csr(mepc_csr),
    .i_mem_req(mem_req), .i_mem_ack(mem_ack), .i_irq(irq), .i_irq_en(irq_en),
    .i_mtvec(mtvec), .i_id_pc(id_pc),
    .o_en_ifid(en_ifid), .o_en_idex(en_idex), .o_en_exmem(en_exmem), .o_en_memwb(en_memwb),
    .o_flush_ifid(fl_ifid), .o_flush_idex(fl_idex), .o_flush_exmem(fl_exmem),
    .o_pc_sel(pc_sel), .o_pc_redir(pc_redir), .o_mepc_we(mepc_we), .o_mepc(mepc),
    .o_irq_ack(irq_ack), .o_mem_err(mem_err), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an interrupt entry is "drain_left non-stalled cycles to go,
  // then one trap cycle"; the watchdog is a plain run-length of stall cycles.
  int          m_drain_left;
  bit          m_trap_now;
  bit          m_lock;
  logic [31:0] m_mepc;
  int          m_stall_run;

  // last cycle's observed outputs, for directed spot checks
  logic [3:0]  obs_en;
  logic [2:0]  obs_fl;
  logic [1:0]  obs_sel;
  logic [31:0] obs_redir, obs_mepc;
  logic        obs_ack, obs_err;

  task automatic model_reset();
    m_drain_left = 0;
    m_trap_now   = 0;
    m_lock       = 0;
    m_mepc       = 32'h0;
    m_stall_run  = 0;
  endtask

  // one clock: compare at negedge, advance model at posedge, inputs may change #1 later
  task automatic tick();
    logic        stall, redirect, new_lock;
    logic [31:0] tgt;
    logic [3:0]  e_en;
    logic [2:0]  e_fl;
    logic [1:0]  e_sel;
    logic [31:0] e_redir, e_mepc;
    logic        e_we, e_ack, e_err;
    @(negedge clk);
    stall    = mem_req && !mem_ack;
    redirect = br_taken || mret;
    tgt      = mret ? mepc_csr : br_target;
    e_en = 4'hf; e_fl = 3'b000; e_sel = 2'd0; e_redir = 32'h0;
    e_we = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_mepc = m_mepc;
    if (rst) begin
      e_fl = 3'b111; e_sel = 2'd1; e_mepc = 32'h0;
    end else begin
      e_err = stall && (((m_stall_run + 1) % (TMO + 1)) == 0);
      if (m_trap_now) begin
        e_fl = 3'b100; e_sel = 2'd2; e_redir = mtvec; e_we = 1'b1; e_ack = 1'b1;
      end else if (stall) begin
        e_en = 4'h0; e_sel = 2'd1;
      end else if (m_drain_left > 0) begin
        e_fl = redirect ? 3'b110 : 3'b100; e_sel = 2'd1;
      end else if (redirect) begin
        e_fl = 3'b110; e_sel = 2'd2; e_redir = tgt;
      end else if (irq && irq_en && !m_lock) begin
        e_fl = 3'b100; e_sel = 2'd1;
      end else if (ld_use) begin
        e_en = 4'b0111; e_fl = 3'b010; e_sel = 2'd1;
      end
    end
    obs_en    = {en_ifid, en_idex, en_exmem, en_memwb};
    obs_fl    = {fl_ifid, fl_idex, fl_exmem};
    obs_sel   = pc_sel;
    obs_redir = pc_redir;
    obs_mepc  = mepc;
    obs_ack   = irq_ack;
    obs_err   = mem_err;
    check("en",     32'(obs_en), 32'(e_en));
    check("flush",  32'(obs_fl), 32'(e_fl));
    check("pc_sel", 32'(obs_sel), 32'(e_sel));
    check("redir",  obs_redir, e_redir);
    check("mepc",   obs_mepc, e_mepc);
    check("we",     32'(mepc_we), 32'(e_we));
    check("ack",    32'(obs_ack), 32'(e_ack));
    check("err",    32'(obs_err), 32'(e_err));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      new_lock    = m_trap_now ? 1'b1 : (irq_en ? m_lock : 1'b0);
      m_stall_run = stall ? m_stall_run + 1 : 0;
      if (m_trap_now) begin
        m_trap_now = 0;
      end else if (m_drain_left > 0) begin
        if (!stall) begin
          if (redirect) m_mepc = tgt;
          m_drain_left--;
          if (m_drain_left == 0) m_trap_now = 1;
        end
      end else if (!stall && !redirect && irq && irq_en && !m_lock) begin
        m_mepc       = id_pc;
        m_drain_left = DRAIN;
      end
      m_lock = new_lock;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ld_use = 0; br_taken = 0; mret = 0; mem_req = 0; mem_ack = 0; irq = 0;
  endtask

  task automatic clear_lock();
    irq_en = 0;
    tick();
    irq_en = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, first_err, err_cnt, ack_cnt;
    model_reset();
    rst = 1; idle_inputs(); irq_en = 0;
    br_target = 32'h0; mepc_csr = 32'h0; mtvec = 32'h0; id_pc = 32'h0;
    tick(); tick();
    check("rst_sel", 32'(obs_sel), 32'(PC_HOLD));
    check("rst_fl", 32'(obs_fl), 32'h7);
    rst = 0;
    tick();
    check("run_sel", 32'(obs_sel), 32'(PC_PLUS4));

    // load-use bubble then normal flow
    ld_use = 1; tick();
    check("lu_en", 32'(obs_en), 32'h7);
    check("lu_fl", 32'(obs_fl), 32'h2);
    ld_use = 0; tick();
    check("lu_next", 32'(obs_sel), 32'(PC_PLUS4));

    // four-cycle SRAM wait, released by ack
    mem_req = 1; mem_ack = 0; n = 0;
    repeat (4) begin tick(); if (obs_en == 4'h0 && obs_fl == 3'h0) n++; end
    check("stall_cycles", 32'(n), 32'd4);
    mem_ack = 1; tick();
    check("ack_en", 32'(obs_en), 32'hf);
    idle_inputs();

    // branch beats load-use
    br_taken = 1; ld_use = 1; br_target = 32'h80; tick();
    check("br_redir", obs_redir, 32'h80);
    check("br_fl", 32'(obs_fl), 32'h6);
    idle_inputs(); tick();

    // interrupt entry: entry cycle + 3 drain cycles, then trap
    id_pc = 32'h100; mtvec = 32'h200; irq = 1; irq_en = 1; n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (obs_ack) begin n = i; break; end
    end
    check("irq_lat", 32'(n), 32'd5);
    check("irq_mepc", obs_mepc, 32'h100);
    check("irq_vec", obs_redir, 32'h200);
    repeat (3) tick();   // level IRQ still high, entry locked out
    check("irq_locked", 32'(obs_sel), 32'(PC_PLUS4));
    clear_lock();

    // entry, IRQ drops, branch in 2nd drain cycle, one stall cycle
    id_pc = 32'h104; irq = 1; tick();
    irq = 0; tick();
    br_taken = 1; br_target = 32'h300; tick();
    br_taken = 0; mem_req = 1; mem_ack = 0; tick();
    mem_req = 0; n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (obs_ack) begin n = i; break; end
    end
    check("drain_br_lat", 32'(n), 32'd2);
    check("drain_br_mepc", obs_mepc, 32'h300);
    clear_lock();

    // long SRAM stall: one error pulse on stall cycle 256
    mem_req = 1; mem_ack = 0; first_err = 0; err_cnt = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (obs_err) begin err_cnt++; if (first_err == 0) first_err = i; end
    end
    check("err_cycle", 32'(first_err), 32'd256);
    check("err_count", 32'(err_cnt), 32'd1);
    mem_ack = 1; tick();
    idle_inputs();

    // reset mid-drain abandons the entry
    clear_lock();
    id_pc = 32'h140; irq = 1; tick();
    irq = 0; tick();
    rst = 1; tick();
    rst = 0; ack_cnt = 0;
    repeat (6) begin tick(); if (obs_ack) ack_cnt++; end
    check("rst_noack", 32'(ack_cnt), 32'd0);
    check("rst_mepc", obs_mepc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      ld_use    = ($urandom_range(0, 4) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      mret      = ($urandom_range(0, 19) == 0);
      mem_req   = ($urandom_range(0, 3) == 0);
      mem_ack   = mem_req && ($urandom_range(0, 1) == 0);
      irq       = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) irq_en = ~irq_en;
      br_target = $urandom;
      mepc_csr  = $urandom;
      mtvec     = $urandom;
      id_pc     = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
